// File: rtl/reg_file_32x32.sv
// 32 x WIDTH register file: r0 reads as zero, two combinational read ports, one write port.
// BYPASS selects whether a same-cycle write is forwarded to the read ports.
module reg_file_32x32 #(
    parameter int WIDTH  = 32,
    parameter int BYPASS = 1
) (
    input  logic             Clk,
    input  logic             Clrn,
    input  logic             We,
    input  logic [4:0]       Wn,
    input  logic [WIDTH-1:0] D,
    input  logic [4:0]       Rna,
    input  logic [4:0]       Rnb,
    output logic [WIDTH-1:0] Qa,
    output logic [WIDTH-1:0] Qb
);

    logic [WIDTH-1:0] r_regs [1:31];
    logic [31:0]      w_strobe;
    logic [WIDTH-1:0] w_rd [0:31];

    // One-hot write decode; bit 0 can never be set, so r0 is never a write target.
    always_comb begin
        w_strobe = '0;
        if (We && (Wn != 5'd0)) begin
            w_strobe = 32'd1 << Wn;
        end
    end

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            for (int i = 1; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (w_strobe[i]) begin
                    r_regs[i] <= D;
                end
            end
        end
    end

    assign w_rd[0] = '0;
    genvar g;
    generate
        for (g = 1; g < 32; g++) begin : g_rd
            assign w_rd[g] = r_regs[g];
        end
    endgenerate

    // Reads are forced to zero while reset is held, including the forwarded value.
    always_comb begin
        Qa = '0;
        Qb = '0;
        if (Clrn) begin
            if ((BYPASS != 0) && w_strobe[Rna]) begin
                Qa = D;
            end else begin
                Qa = w_rd[Rna];
            end
            if ((BYPASS != 0) && w_strobe[Rnb]) begin
                Qb = D;
            end else begin
                Qb = w_rd[Rnb];
            end
        end
    end

endmodule

// File: tb/tb_reg_file_32x32.sv
// Bench for reg_file_32x32: drives a bypassing and a non-bypassing instance from shared
// inputs and compares both against an array model of the register file.
module tb_reg_file_32x32;

    logic        clk;
    logic        clrn;
    logic        we;
    logic [4:0]  wn;
    logic [31:0] d;
    logic [4:0]  rna;
    logic [4:0]  rnb;
    logic [31:0] qa_byp, qb_byp, qa_nob, qb_nob;

    logic [31:0] mdl [32];
    int total;
    int bad;

    reg_file_32x32 #(.WIDTH(32), .BYPASS(1)) u_dut_byp (
        .Clk(clk), .Clrn(clrn), .We(we), .Wn(wn), .D(d),
        .Rna(rna), .Rnb(rnb), .Qa(qa_byp), .Qb(qb_byp)
    );

    reg_file_32x32 #(.WIDTH(32), .BYPASS(0)) u_dut_nob (
        .Clk(clk), .Clrn(clrn), .We(we), .Wn(wn), .D(d),
        .Rna(rna), .Rnb(rnb), .Qa(qa_nob), .Qb(qb_nob)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t actual=%h expected=%h", tag, $time, act, exp);
        end
    endtask

    // What a read port should show for the current inputs, straight from the rules.
    function automatic logic [31:0] exp_rd(input bit byp, input logic [4:0] rn);
        if (!clrn || rn == 5'd0) return 32'h0;
        if (byp && we && wn == rn) return d;
        return mdl[rn];
    endfunction

    task automatic check_outs(input string tag);
        check({tag, " qa_byp"}, qa_byp, exp_rd(1'b1, rna));
        check({tag, " qb_byp"}, qb_byp, exp_rd(1'b1, rnb));
        check({tag, " qa_nob"}, qa_nob, exp_rd(1'b0, rna));
        check({tag, " qb_nob"}, qb_nob, exp_rd(1'b0, rnb));
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    endtask

    // One cycle: set inputs after the falling edge, check before and after the rising edge.
    task automatic apply(input string tag, input logic i_we, input logic [4:0] i_wn,
                         input logic [31:0] i_d, input logic [4:0] i_rna, input logic [4:0] i_rnb,
                         input bit post_chk);
        @(negedge clk);
        we = i_we; wn = i_wn; d = i_d; rna = i_rna; rnb = i_rnb;
        #1 check_outs({tag, " pre"});
        @(posedge clk);
        if (clrn && we && wn != 5'd0) mdl[wn] = d;
        if (post_chk) begin
            #1 check_outs({tag, " post"});
        end
    endtask

    task automatic sweep_reads(input string tag);
        for (int i = 0; i < 32; i++) begin
            apply(tag, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 1'b0);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clrn = 1'b0; we = 1'b0; wn = '0; d = '0; rna = '0; rnb = '0;
        clear_model();
        #1 check_outs("in_reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        clrn = 1'b1;

        sweep_reads("after_reset");

        apply("w_r5", 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 1'b0);
        apply("w_r31", 1'b1, 5'd31, 32'h12345678, 5'd0, 5'd0, 1'b0);
        apply("rd_5_31", 1'b0, 5'd0, 32'h0, 5'd5, 5'd31, 1'b0);
        check("r5 literal", qa_byp, 32'hDEADBEEF);
        check("r31 literal", qb_nob, 32'h12345678);
        sweep_reads("others_zero");

        apply("w_r0", 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b1);
        check("r0 literal", qa_byp, 32'h0);
        sweep_reads("after_w_r0");

        apply("w_r7", 1'b1, 5'd7, 32'h11111111, 5'd0, 5'd0, 1'b0);
        apply("bypass_r7", 1'b1, 5'd7, 32'h22222222, 5'd7, 5'd7, 1'b1);
        apply("bypass_r7_lit", 1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 1'b0);
        check("r7 after edge", qa_nob, 32'h22222222);

        // Same-cycle forwarding: literal values before the edge.
        @(negedge clk);
        we = 1'b1; wn = 5'd7; d = 32'h33333333; rna = 5'd7; rnb = 5'd7;
        #1;
        check("byp qa lit", qa_byp, 32'h33333333);
        check("byp qb lit", qb_byp, 32'h33333333);
        check("nob qa lit", qa_nob, 32'h22222222);
        check("nob qb lit", qb_nob, 32'h22222222);
        @(posedge clk);
        mdl[7] = 32'h33333333;

        for (int i = 1; i < 32; i++) begin
            apply("load_idx", 1'b1, 5'(i), 32'(i), 5'(i), 5'(i - 1), 1'b0);
        end

        // Reset asserted mid-cycle with a write to r9 pending; held across a rising edge.
        @(negedge clk);
        we = 1'b1; wn = 5'd9; d = 32'hCAFEF00D; rna = 5'd9; rnb = 5'd9;
        #2 clrn = 1'b0;
        clear_model();
        for (int i = 0; i < 32; i++) begin
            rna = 5'(i); rnb = 5'(31 - i);
            #1 check_outs("reset_low");
        end
        @(negedge clk);
        we = 1'b0; clrn = 1'b1; rna = 5'd9; rnb = 5'd1;
        #1 check_outs("after_release");
        check("r9 lost", qa_nob, 32'h0);

        apply("first_write", 1'b1, 5'd9, 32'h99999999, 5'd9, 5'd9, 1'b1);
        check("r9 written", qa_nob, 32'h99999999);

        for (int n = 0; n < 1000; n++) begin
            logic        r_we;
            logic [4:0]  r_wn, r_ra, r_rb;
            logic [31:0] r_d;
            r_we = 1'($urandom_range(0, 1));
            r_wn = 5'($urandom_range(0, 31));
            r_d  = $urandom;
            r_ra = ($urandom_range(0, 3) == 0) ? r_wn : 5'($urandom_range(0, 31));
            r_rb = ($urandom_range(0, 3) == 0) ? r_ra : 5'($urandom_range(0, 31));
            apply("rand", r_we, r_wn, r_d, r_ra, r_rb, 1'b0);
        end
        sweep_reads("final_sweep");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
